// File: rtl/mdu_exec_unit.sv
// mdu_exec_unit: multiply/divide execution unit, one operation in flight.
// Multiplies spend MUL_LAT cycles in MUL; divides run a radix-2 restoring
// loop over DATA_W cycles followed by a one-cycle sign fix-up. The result
// is held under valid/ready until the downstream FIFO takes it.
// Optional build macro MDU_DIV_BYPASS_EN: divides whose quotient is
// trivially 0 or all-ones (|dividend| < |divisor|, or divisor == 0) skip
// the iterative loop and go straight to the fix-up cycle.
module mdu_exec_unit #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] src0_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [TAG_W-1:0]  tag_o
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  // Absolute value; the most negative input maps onto itself, which read
  // as unsigned is exactly its magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] u;
    u = x;
    return x[DATA_W-1] ? -u : u;
  endfunction

  function automatic logic [DATA_W-1:0] negate_if(input logic [DATA_W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  state_t                  state;
  state_t                  start_state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        start_cnt;
  logic [1:0]              op_r;
  logic [TAG_W-1:0]        tag_r;
  logic [DATA_W-1:0]       a_r;
  logic [DATA_W-1:0]       b_r;
  logic [DATA_W-1:0]       rem_r;
  logic                    neg_q;
  logic                    neg_r;

  logic                    accept;
  logic                    sgn_div;
  logic [DATA_W-1:0]       src0_mag;
  logic [DATA_W-1:0]       src1_mag;
  logic [DATA_W:0]         shifted;
  logic [DATA_W:0]         diff;
  logic [2*DATA_W-1:0]     a_ext;
  logic [2*DATA_W-1:0]     b_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]       mul_res;
  logic [DATA_W-1:0]       div_res;

  assign ready_o = ((state == IDLE) | ((state == DONE) & ready_i)) & ~flush;
  assign valid_o = (state == DONE);
  assign accept  = valid_i & ready_o;

  // DIV/MOD (op 4/5) are the signed divides; op[1] set marks unsigned.
  assign sgn_div  = ~op_i[1];
  assign src0_mag = sgn_div ? magnitude(src0_i) : src0_i;
  assign src1_mag = sgn_div ? magnitude(src1_i) : src1_i;

`ifdef MDU_DIV_BYPASS_EN
  logic bypass;
  assign bypass      = (src1_mag == '0) | (src0_mag < src1_mag);
  assign start_state = !op_i[2] ? MUL : (bypass ? FIX : DIV);
`else
  assign start_state = op_i[2] ? DIV : MUL;
`endif
  assign start_cnt = op_i[2] ? CNT_W'(DATA_W - 1) : CNT_W'(MUL_LAT - 1);

  // One restoring step: shift in the next dividend bit and trial-subtract.
  assign shifted = {rem_r, a_r[DATA_W-1]};
  assign diff    = shifted - {1'b0, b_r};

  // Only MULH sign-extends; MUL, MULHU and the reserved opcode zero-extend.
  assign a_ext   = (op_r == 2'b01) ? {{DATA_W{a_r[DATA_W-1]}}, a_r} : {{DATA_W{1'b0}}, a_r};
  assign b_ext   = (op_r == 2'b01) ? {{DATA_W{b_r[DATA_W-1]}}, b_r} : {{DATA_W{1'b0}}, b_r};
  assign prod    = $signed(a_ext) * $signed(b_ext);
  assign mul_res = ((op_r == 2'b01) || (op_r == 2'b10)) ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];

  // op[0] selects remainder (MOD/MODU) over quotient (DIV/DIVU).
  assign div_res = op_r[0] ? negate_if(rem_r, neg_r) : negate_if(a_r, neg_q);

  // Control FSM: sequencing, latency counter, flush/reset kill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      state <= start_state;
      cnt   <= start_cnt;
    end else begin
      case (state)
        MUL: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        DIV: begin
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CNT_W'(1);
        end
        FIX:     state <= DONE;
        DONE:    if (ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture and divider iteration; the quotient shifts into a_r
  // as the dividend bits shift out of it.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r  <= op_i[1:0];
      tag_r <= tag_i;
      neg_q <= op_i[2] & sgn_div & (src0_i[DATA_W-1] ^ src1_i[DATA_W-1]) & (src1_i != '0);
      neg_r <= op_i[2] & sgn_div & src0_i[DATA_W-1];
      rem_r <= '0;
      if (op_i[2]) begin
        a_r <= src0_mag;
        b_r <= src1_mag;
`ifdef MDU_DIV_BYPASS_EN
        if (bypass) begin
          a_r   <= (src1_mag == '0) ? '1 : '0;
          rem_r <= src0_mag;
        end
`endif
      end else begin
        a_r <= src0_i;
        b_r <= src1_i;
      end
    end else if (state == DIV) begin
      a_r   <= {a_r[DATA_W-2:0], ~diff[DATA_W]};
      rem_r <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    end
  end

  // Result register, loaded on the cycle before DONE and held through it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_o <= '0;
      tag_o  <= '0;
    end else if (!flush && (state == MUL) && (cnt == '0)) begin
      data_o <= mul_res;
      tag_o  <= tag_r;
    end else if (!flush && (state == FIX)) begin
      data_o <= div_res;
      tag_o  <= tag_r;
    end
  end

endmodule

// File: tb/tb_mdu_exec_unit.sv
// tb_mdu_exec_unit: scoreboard bench for mdu_exec_unit. Expected results
// and latencies are pushed when a request is accepted and compared when
// the unit hands a result downstream.
module tb_mdu_exec_unit;

  localparam int DATA_W  = 32;
  localparam int TAG_W   = 6;
  localparam int MUL_LAT = 2;
`ifdef MDU_DIV_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              valid_i;
  logic              ready_o;
  logic [2:0]        op_i;
  logic [DATA_W-1:0] src0_i;
  logic [DATA_W-1:0] src1_i;
  logic [TAG_W-1:0]  tag_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [TAG_W-1:0]  tag_o;

  mdu_exec_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .src0_i(src0_i), .src1_i(src1_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    int                acc;
    int                lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] model(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    longint          sa;
    longint          sbv;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    case (op)
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = sa / sbv; return p[31:0]; end
      3'd5: begin if (b == 0) return a;  p = sa % sbv; return p[31:0]; end
      3'd6: begin if (b == 0) return '1; return a / b; end
      3'd7: begin if (b == 0) return a;  return a % b; end
      default: begin p = ua * ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] ma;
    logic [DATA_W-1:0] mb;
    if (!op[2]) return MUL_LAT + 1;
    ma = (!op[1] && a[31]) ? -a : a;
    mb = (!op[1] && b[31]) ? -b : b;
    if (BYPASS && ((mb == 0) || (ma < mb))) return 2;
    return DATA_W + 2;
  endfunction

  // Present a request from posedge+1; returns at posedge+1 after acceptance.
  task automatic issue(input logic [2:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [TAG_W-1:0] tag, output int acc);
    exp_t e;
    int   n;
    valid_i = 1'b1;
    op_i    = op;
    src0_i  = a;
    src1_i  = b;
    tag_i   = tag;
    acc     = -1;
    n       = 0;
    @(negedge clk);
    while (!ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!ready_o) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      e.data = model(op, a, b);
      e.tag  = tag;
      e.acc  = cyc;
      e.lat  = exp_lat(op, a, b);
      sb.push_back(e);
      acc = cyc;
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    op_i    = 3'($urandom);
    src0_i  = $urandom;
    src1_i  = $urandom;
    tag_i   = TAG_W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sb.size() != 0 && n < 200);
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!valid_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!valid_o) chk(name, 64'd0, 64'd1);
  endtask

  // Output monitor: latency from accept to first valid, data and tag at handshake.
  int first_cyc = 0;
  bit in_done   = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!valid_o) in_done = 1'b0;
      else if (!in_done) begin
        in_done   = 1'b1;
        first_cyc = cyc;
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("data tag%0d", e.tag), 64'(data_o), 64'(e.data));
          chk($sformatf("tag tag%0d", e.tag), 64'(tag_o), 64'(e.tag));
          chk($sformatf("latency tag%0d", e.tag), 64'(first_cyc - e.acc), 64'(e.lat));
        end
        in_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  typedef struct {
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int acc;
    int acc_prev;
    int rel;
    int seen;
    logic [DATA_W-1:0] exp_v;

    rst_n   = 1'b0;
    flush   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_i    = '0;
    src0_i  = '0;
    src1_i  = '0;
    tag_i   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_data", 64'(data_o), 64'd0);
    chk("reset_tag", 64'(tag_o), 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First multiply, then ready_o must return once the result is taken.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 6'd5, acc);
    drain();
    @(negedge clk);
    chk("ready_after_mul", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;

    // Directed cases: high-half multiplies, signed divide, corner divides.
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2});
    vecs.push_back('{3'd5, 32'hFFFF_FFF9, 32'd2});
    vecs.push_back('{3'd6, 32'd5, 32'd0});
    vecs.push_back('{3'd7, 32'd5, 32'd0});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF});
    vecs.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0});
    vecs.push_back('{3'd5, 32'hFFFF_FFF9, 32'd0});
    vecs.push_back('{3'd6, 32'd3, 32'd10});
    vecs.push_back('{3'd5, 32'hFFFF_FFFD, 32'd10});
    vecs.push_back('{3'd3, 32'h1234_5678, 32'h9ABC_DEF0});
    vecs.push_back('{3'd7, 32'hDEAD_BEEF, 32'h0000_1234});
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 6'(10 + i), acc);
      drain();
    end

    // Random operations, with small divisors mixed in.
    for (int i = 0; i < 16; i++) begin
      logic [DATA_W-1:0] rb;
      rb = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 5)) : $urandom;
      issue(3'($urandom), $urandom, rb, 6'(32 + i), acc);
      drain();
    end

    // Back-to-back multiplies: one accept every MUL_LAT+1 cycles.
    issue(3'd0, 32'd3, 32'd4, 6'd50, acc_prev);
    for (int i = 1; i < 4; i++) begin
      issue(3'd1, 32'h8000_0000 + 32'(i), 32'hF000_0000, 6'(50 + i), acc);
      chk($sformatf("b2b_spacing%0d", i), 64'(acc - acc_prev), 64'(MUL_LAT + 1));
      acc_prev = acc;
    end
    drain();

    // Stall in DONE: outputs hold for 10 cycles and ready_o stays low.
    ready_i = 1'b0;
    issue(3'd2, 32'hCAFE_F00D, 32'h1357_9BDF, 6'd9, acc);
    exp_v = model(3'd2, 32'hCAFE_F00D, 32'h1357_9BDF);
    wait_valid("stall_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 64'(valid_o), 64'd1);
      chk("stall_data", 64'(data_o), 64'(exp_v));
      chk("stall_tag", 64'(tag_o), 64'd9);
      chk("stall_ready", 64'(ready_o), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    rel     = cyc;
    issue(3'd0, 32'd100, 32'd200, 6'd11, acc);
    chk("b2b_no_bubble", 64'(acc), 64'(rel));
    drain();

    // Flush in the middle of a divide.
    issue(3'd4, 32'hFFFF_FF9C, 32'd7, 6'd20, acc);
    repeat (13) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready_low", 64'(ready_o), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("ready_after_flush", 64'(ready_o), 64'd1);
    seen = 0;
    repeat (40) begin
      if (valid_o) seen++;
      @(negedge clk);
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    issue(3'd0, 32'hFFFF_FFFF, 32'd2, 6'd21, acc);
    drain();

    // Reset while a result is held in DONE.
    ready_i = 1'b0;
    issue(3'd0, 32'd6, 32'd7, 6'd33, acc);
    wait_valid("rst_valid_timeout");
    chk("pre_rst_data", 64'(data_o), 64'd42);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    issue(3'd6, 32'd100, 32'd7, 6'd34, acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
